span_fill: RTL and testbench

Scanline span filler: the consumer end of the filled-triangle rasterizer's span output. It accepts one horizontal span per handshake (row y, two unordered endpoints), orders and clips it to the display, then emits one pixel per cycle as coordinates plus a linear framebuffer address. It sits between the triangle span generator and the framebuffer write port.

---
 rtl/span_fill_pkg.sv | 27 ++
 rtl/span_clip.sv | 50 +++++
 rtl/span_fill.sv | 132 +++++++++++++
 tb/tb_span_fill.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/span_fill_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : span_fill_pkg
//  Description : Shared graphics definitions: display size defaults, span
//                filler state encoding and the span record type.
//  Revision    : 1.0 - initial release
// ============================================================================
package span_fill_pkg;

  // Display geometry shared with the triangle rasterizer
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;

  // Span filler state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CLIP = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;

  // One horizontal span as delivered by the span generator
  typedef struct packed {
    logic signed [31:0] y;
    logic signed [31:0] xa;
    logic signed [31:0] xb;
  } span_rec_t;

endpackage
`default_nettype wire

// File: rtl/span_clip.sv
`default_nettype none
// ============================================================================
//  Module      : span_clip
//  Description : Combinational span ordering, clamping to the display and
//                off-screen test; also forms the framebuffer base address.
//  Revision    : 1.0 - initial release
// ============================================================================
module span_clip
  import span_fill_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 19
) (
  input  span_rec_t          i_span,
  output logic               o_drop,
  output logic [15:0]        o_cur_x,
  output logic [15:0]        o_end_x,
  output logic [ADDR_W-1:0]  o_base
);

  localparam logic signed [31:0] c_h_res = 32'(H_RES);
  localparam logic signed [31:0] c_v_res = 32'(V_RES);

  logic signed [31:0] w_y;
  logic signed [31:0] w_xa;
  logic signed [31:0] w_xb;
  logic signed [31:0] w_lo;
  logic signed [31:0] w_hi;
  logic signed [31:0] w_cur;
  logic signed [31:0] w_end;

  // Order the endpoints, test visibility and clamp to the visible columns
  always_comb begin
    w_y   = i_span.y;
    w_xa  = i_span.xa;
    w_xb  = i_span.xb;
    w_lo  = (w_xa < w_xb) ? w_xa : w_xb;
    w_hi  = (w_xa < w_xb) ? w_xb : w_xa;
    o_drop = (w_y < 32'sd0) || (w_y >= c_v_res) ||
             (w_hi < 32'sd0) || (w_lo >= c_h_res);
    w_cur = (w_lo < 32'sd0) ? 32'sd0 : w_lo;
    w_end = (w_hi > (c_h_res - 32'sd1)) ? (c_h_res - 32'sd1) : w_hi;
    o_cur_x = 16'(w_cur);
    o_end_x = 16'(w_end);
    o_base  = ADDR_W'(w_y * c_h_res + w_cur);
  end

endmodule
`default_nettype wire

// File: rtl/span_fill.sv
`default_nettype none
// ============================================================================
//  Module      : span_fill
//  Description : Scanline span filler. Accepts one span per handshake,
//                clips it to the display and emits one pixel per cycle with
//                its coordinates and linear framebuffer address.
//  Revision    : 1.0 - initial release
// ============================================================================
module span_fill
  import span_fill_pkg::*;
#(
  parameter int H_RES  = H_RES_DEF,
  parameter int V_RES  = V_RES_DEF,
  parameter int ADDR_W = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               span_valid,
  output logic               span_ready,
  input  logic signed [31:0] span_y,
  input  logic signed [31:0] span_xa,
  input  logic signed [31:0] span_xb,
  output logic               px_valid,
  input  logic               px_ready,
  output logic [15:0]        px_x,
  output logic [15:0]        px_y,
  output logic [ADDR_W-1:0]  px_addr,
  output logic               px_last,
  output logic               span_done,
  output logic [15:0]        drop_cnt
);

  logic [1:0]        r_state;
  logic [1:0]        w_next;
  span_rec_t         r_span;
  logic [15:0]       r_cur;
  logic [15:0]       r_end;
  logic [15:0]       r_y;
  logic [ADDR_W-1:0] r_addr;
  logic              r_done_fin;
  logic [15:0]       r_drop_cnt;

  logic              w_drop;
  logic [15:0]       w_cur_x;
  logic [15:0]       w_end_x;
  logic [ADDR_W-1:0] w_base;
  logic              w_hs_in;
  logic              w_hs_px;
  logic              w_at_end;

  span_clip #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .ADDR_W (ADDR_W)
  ) u_clip (
    .i_span  (r_span),
    .o_drop  (w_drop),
    .o_cur_x (w_cur_x),
    .o_end_x (w_end_x),
    .o_base  (w_base)
  );

  assign w_hs_in  = span_valid && span_ready;
  assign w_at_end = (r_cur == r_end);
  assign w_hs_px  = (r_state == ST_EMIT) && px_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic: one CLIP cycle per span, then EMIT until the last beat
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_hs_in) w_next = ST_CLIP;
      ST_CLIP: w_next = w_drop ? ST_IDLE : ST_EMIT;
      ST_EMIT: if (px_ready && w_at_end) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; a drop pulses done during CLIP itself
  always_comb begin
    span_ready = (r_state == ST_IDLE) && !reset;
    px_valid   = (r_state == ST_EMIT);
    px_last    = (r_state == ST_EMIT) && w_at_end;
    span_done  = ((r_state == ST_CLIP) && w_drop) || r_done_fin;
  end

  // Span capture, pixel counter, address stepping and drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_span     <= '0;
      r_cur      <= '0;
      r_end      <= '0;
      r_y        <= '0;
      r_addr     <= '0;
      r_done_fin <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      r_done_fin <= w_hs_px && w_at_end;
      if (r_state == ST_IDLE && w_hs_in) begin
        r_span.y  <= span_y;
        r_span.xa <= span_xa;
        r_span.xb <= span_xb;
      end
      if (r_state == ST_CLIP) begin
        if (w_drop) begin
          if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
        end else begin
          r_cur  <= w_cur_x;
          r_end  <= w_end_x;
          r_y    <= 16'(r_span.y);
          r_addr <= w_base;
        end
      end
      if (w_hs_px && !w_at_end) begin
        r_cur  <= r_cur + 16'd1;
        r_addr <= r_addr + ADDR_W'(1);
      end
    end
  end

  assign px_x     = r_cur;
  assign px_y     = r_y;
  assign px_addr  = r_addr;
  assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_span_fill.sv
`default_nettype none
// ============================================================================
//  Module      : tb_span_fill
//  Description : Scoreboard bench for span_fill: every offered span is
//                expanded by a reference model into expected pixels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_span_fill;

  localparam int H = 640;
  localparam int V = 480;
  localparam int AW = 19;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              span_valid = 1'b0;
  logic              span_ready;
  logic signed [31:0] span_y = '0;
  logic signed [31:0] span_xa = '0;
  logic signed [31:0] span_xb = '0;
  logic              px_valid;
  logic              px_ready = 1'b1;
  logic [15:0]       px_x;
  logic [15:0]       px_y;
  logic [AW-1:0]     px_addr;
  logic              px_last;
  logic              span_done;
  logic [15:0]       drop_cnt;

  typedef struct {
    int x;
    int y;
    int addr;
    bit last;
  } pix_t;

  pix_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   hs_cyc = 0;
  int   first_cyc = 0;
  int   last_cyc = 0;
  bit   in_span = 0;
  int   done_cnt = 0;
  int   exp_done = 0;
  int   rdy_mode = 0;

  span_fill #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .span_valid (span_valid),
    .span_ready (span_ready),
    .span_y     (span_y),
    .span_xa    (span_xa),
    .span_xb    (span_xb),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_x       (px_x),
    .px_y       (px_y),
    .px_addr    (px_addr),
    .px_last    (px_last),
    .span_done  (span_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: order, visibility test, clamp, expand into pixels
  task automatic model_span(input int y, input int xa, input int xb);
    int lo, hi, s, e;
    pix_t p;
    lo = (xa < xb) ? xa : xb;
    hi = (xa < xb) ? xb : xa;
    if (y < 0 || y >= V || hi < 0 || lo >= H) return;
    s = (lo < 0) ? 0 : lo;
    e = (hi > H - 1) ? H - 1 : hi;
    for (int x = s; x <= e; x++) begin
      p.x = x; p.y = y; p.addr = y * H + x; p.last = (x == e);
      q.push_back(p);
    end
  endtask

  task automatic send_span(input int y, input int xa, input int xb);
    bit got;
    model_span(y, xa, xb);
    exp_done++;
    @(posedge clk); #1;
    span_valid = 1'b1; span_y = y; span_xa = xa; span_xb = xb;
    got = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(negedge clk);
      if (span_ready) begin got = 1; hs_cyc = cyc; end
      @(posedge clk); #1;
    end
    span_valid = 1'b0;
    if (!got) check("span_hs_timeout", 32'(got), 32'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 4000 && !ok; i++) begin
      @(negedge clk);
      if (q.size() == 0 && span_ready) ok = 1;
    end
    if (!ok) check("drain_timeout", 32'(q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // px_ready pattern: 0 = always ready, 1 = toggle, 2 = random
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       px_ready = ~px_ready;
        2:       px_ready = 1'($urandom);
        default: px_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: every valid beat must match the scoreboard head
  always @(negedge clk) begin
    if (!reset) begin
      if (span_done) done_cnt++;
      if (px_valid && q.size() == 0) check("unexpected_px", 32'(px_valid), 32'd0);
      if (px_valid && q.size() != 0) begin
        check("px_x",    32'(px_x),    32'(q[0].x));
        check("px_y",    32'(px_y),    32'(q[0].y));
        check("px_addr", 32'(px_addr), 32'(q[0].addr));
        check("px_last", 32'(px_last), 32'(q[0].last));
        if (px_ready) begin
          if (!in_span) first_cyc = cyc;
          in_span = 1;
          if (q[0].last) begin last_cyc = cyc; in_span = 0; end
          void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    bit hit;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_span_ready", 32'(span_ready), 32'd0);
    check("rst_px_valid",   32'(px_valid),   32'd0);
    check("rst_px_last",    32'(px_last),    32'd0);
    check("rst_span_done",  32'(span_done),  32'd0);
    check("rst_px_x",       32'(px_x),       32'd0);
    check("rst_px_y",       32'(px_y),       32'd0);
    check("rst_px_addr",    32'(px_addr),    32'd0);
    check("rst_drop_cnt",   32'(drop_cnt),   32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(span_ready), 32'd1);

    // Reversed endpoints, full-speed output
    send_span(40, 35, 10);
    drain();
    check("t1_latency", 32'(first_cyc - hs_cyc), 32'd2);
    check("t1_beats",   32'(last_cyc - first_cyc), 32'd25);
    check("t1_done",    32'(done_cnt), 32'(exp_done));

    // Left and right clipping
    send_span(5, -3, 2);
    send_span(0, 630, 700);
    drain();
    check("t2_done", 32'(done_cnt), 32'(exp_done));

    // Fully off-screen spans are dropped
    send_span(480, 0, 5);
    send_span(10, -9, -1);
    drain();
    check("t3_drop_cnt", 32'(drop_cnt), 32'd2);
    check("t3_done",     32'(done_cnt), 32'(exp_done));

    // Degenerate span under back-pressure
    rdy_mode = 1;
    send_span(1, 7, 7);
    drain();
    check("t4_done", 32'(done_cnt), 32'(exp_done));

    // Random spans with random back-pressure
    rdy_mode = 2;
    for (int i = 0; i < 8; i++)
      send_span(int'($urandom_range(490)) - 5, int'($urandom_range(760)) - 60,
                int'($urandom_range(760)) - 60);
    drain();
    check("t5_done",     32'(done_cnt), 32'(exp_done));
    rdy_mode = 0;
    repeat (2) @(negedge clk);

    // Reset while the third pixel is on the output
    send_span(2, 0, 9);
    hit = 0;
    for (int i = 0; i < 50 && !hit; i++) begin
      @(negedge clk);
      if (px_valid && px_x == 16'd2) hit = 1;
    end
    check("t6_reach_px2", 32'(hit), 32'd1);
    reset = 1'b1;
    q.delete();
    in_span = 0;
    exp_done--;
    @(negedge clk);
    check("t6_px_valid", 32'(px_valid),  32'd0);
    check("t6_done",     32'(span_done), 32'd0);
    check("t6_drop_cnt", 32'(drop_cnt),  32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t6_ready",    32'(span_ready), 32'd1);
    check("t6_done_rel", 32'(span_done),  32'd0);
    send_span(3, 104, 100);
    drain();
    check("t6_after_done", 32'(done_cnt), 32'(exp_done));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
